// File: rtl/oled_i2c_txn_sequencer_if.sv
// Request, payload stream and byte-engine handshake bundle around the SSD1306 transaction sequencer.
// The master modport is the sequencer's view; slave is the requester/engine side.
interface oled_i2c_txn_sequencer_if;
   logic       start;
   logic [7:0] len;
   logic       dc;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [1:0] i2c_instruction;
   logic       i2c_enable;
   logic [7:0] i2c_byte;
   logic       i2c_complete;

   modport master (
      input  start, len, dc, data_in, data_valid, i2c_complete,
      output busy, done, err, data_ready, i2c_instruction, i2c_enable, i2c_byte
   );

   modport slave (
      output start, len, dc, data_in, data_valid, i2c_complete,
      input  busy, done, err, data_ready, i2c_instruction, i2c_enable, i2c_byte
   );
endinterface

// File: rtl/oled_i2c_txn_sequencer.sv
// Drives the byte-level I2C engine through one SSD1306 write transaction per request:
// START, address, control byte, len payload bytes from a valid/ready stream, STOP, with a per-phase watchdog.
module oled_i2c_txn_sequencer #(
   parameter logic [6:0] ADDR      = 7'h3C,
   parameter logic [7:0] CTRL_CMD  = 8'h00,
   parameter logic [7:0] CTRL_DATA = 8'h40,
   parameter int         TIMEOUT   = 4096
) (
   input logic clk,
   input logic rst,
   oled_i2c_txn_sequencer_if.master bus
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_CTRL  = 3'd3;
   localparam logic [2:0] S_FETCH = 3'd4;
   localparam logic [2:0] S_DATA  = 3'd5;
   localparam logic [2:0] S_STOP  = 3'd6;

   localparam logic [1:0] I_START = 2'd0;
   localparam logic [1:0] I_STOP  = 2'd1;
   localparam logic [1:0] I_WRITE = 2'd3;

   localparam int             WDW    = $clog2(TIMEOUT);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT - 1);

   logic [2:0]     state;
   logic [7:0]     remaining;
   logic           dcLat;
   logic           busyR, doneR, errR, readyR, enR;
   logic [1:0]     instrR;
   logic [7:0]     byteR;
   logic [WDW-1:0] wdog;

   assign bus.busy            = busyR;
   assign bus.done            = doneR;
   assign bus.err             = errR;
   assign bus.data_ready      = readyR;
   assign bus.i2c_enable      = enR;
   assign bus.i2c_instruction = instrR;
   assign bus.i2c_byte        = byteR;

   // In an engine-op state, enR doubles as the phase flag: 1 = ISSUE, 0 = RELEASE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         remaining <= 8'd0;
         dcLat     <= 1'b0;
         busyR     <= 1'b0;
         doneR     <= 1'b0;
         errR      <= 1'b0;
         readyR    <= 1'b0;
         enR       <= 1'b0;
         instrR    <= I_START;
         byteR     <= 8'd0;
         wdog      <= '0;
      end else begin
         doneR <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  remaining <= bus.len;
                  dcLat     <= bus.dc;
                  busyR     <= 1'b1;
                  errR      <= 1'b0;
                  state     <= S_START;
                  enR       <= 1'b1;
                  instrR    <= I_START;
                  wdog      <= '0;
               end
            end
            S_FETCH: begin
               if (bus.data_valid) begin
                  byteR     <= bus.data_in;
                  remaining <= remaining - 8'd1;
                  readyR    <= 1'b0;
                  state     <= S_DATA;
                  enR       <= 1'b1;
                  instrR    <= I_WRITE;
                  wdog      <= '0;
               end
            end
            default: begin
               if (enR ? bus.i2c_complete : !bus.i2c_complete) begin
                  wdog <= '0;
                  if (enR) begin
                     enR <= 1'b0;
                  end else begin
                     case (state)
                        S_START: begin
                           state  <= S_ADDR;
                           enR    <= 1'b1;
                           instrR <= I_WRITE;
                           byteR  <= {ADDR, 1'b0};
                        end
                        S_ADDR: begin
                           state  <= S_CTRL;
                           enR    <= 1'b1;
                           instrR <= I_WRITE;
                           byteR  <= dcLat ? CTRL_DATA : CTRL_CMD;
                        end
                        S_CTRL, S_DATA: begin
                           if (remaining == 8'd0) begin
                              state  <= S_STOP;
                              enR    <= 1'b1;
                              instrR <= I_STOP;
                           end else begin
                              state  <= S_FETCH;
                              readyR <= 1'b1;
                           end
                        end
                        S_STOP: begin
                           state <= S_IDLE;
                           busyR <= 1'b0;
                           doneR <= 1'b1;
                        end
                        default: begin
                           state <= S_IDLE;
                           busyR <= 1'b0;
                        end
                     endcase
                  end
               end else if (wdog == WD_MAX) begin
                  // Abort without STOP; the next transaction re-synchronises the bus with START.
                  enR   <= 1'b0;
                  doneR <= 1'b1;
                  errR  <= 1'b1;
                  busyR <= 1'b0;
                  state <= S_IDLE;
                  wdog  <= '0;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
         endcase
      end
   end
endmodule
